// File: rtl/rgb2yuv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2yuv_pkg
//  Purpose  : Shared types and constants for the RGB-to-YUV frame sequencer:
//             FSM state encoding, datapath control-word field layout, the
//             fixed control words and the per-mode microcode schedules.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rgb2yuv_pkg;

  // Geometry of the schedule table held in this package.
  localparam int CTRL_WORD_W = 22;
  localparam int SCHED_MODES = 2;
  localparam int SCHED_STEPS = 10;

  // Sequencer states. Encodings 5..7 are unreachable.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Control-word field offsets.
  //   [2:0]   output register enables (Y, U, V)
  //   [3]     pixel input register load
  //   [4]     accumulator clear (load product instead of add)
  //   [5]     accumulator enable
  //   [7:6]   multiplier operand select (R, G, B, accumulator)
  //   [12:8]  coefficient ROM select
  //   [13]    chroma offset add
  //   [14]    round / clamp pass
  //   [15]    hold: output registers keep their value
  //   [21:16] reserved, always zero
  localparam int F_WR_Y     = 0;
  localparam int F_WR_U     = 1;
  localparam int F_WR_V     = 2;
  localparam int F_LD_PIX   = 3;
  localparam int F_ACC_CLR  = 4;
  localparam int F_ACC_EN   = 5;
  localparam int F_MUL_SEL  = 6;
  localparam int MUL_SEL_W  = 2;
  localparam int F_COEF_SEL = 8;
  localparam int COEF_SEL_W = 5;
  localparam int F_OFS_EN   = 13;
  localparam int F_RND      = 14;
  localparam int F_HOLD     = 15;

  // Multiplier operand select codes.
  localparam logic [1:0] MUL_R   = 2'd0;
  localparam logic [1:0] MUL_G   = 2'd1;
  localparam logic [1:0] MUL_B   = 2'd2;
  localparam logic [1:0] MUL_ACC = 2'd3;

  typedef logic [CTRL_WORD_W-1:0] ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '0;
  localparam ctrl_word_t CTRL_LOAD = (ctrl_word_t'(1) << F_LD_PIX) |
                                     (ctrl_word_t'(1) << F_ACC_CLR);
  localparam ctrl_word_t CTRL_HOLD = ctrl_word_t'(1) << F_HOLD;

  // Assembles one micro-op from its fields.
  function automatic ctrl_word_t f_uop(
    input logic [1:0] mul_sel,
    input logic [4:0] coef,
    input logic [2:0] wr,
    input logic       acc_clr,
    input logic       acc_en,
    input logic       ofs,
    input logic       rnd
  );
    ctrl_word_t w;
    w = '0;
    w[F_WR_Y +: 3]                 = wr;
    w[F_ACC_CLR]                   = acc_clr;
    w[F_ACC_EN]                    = acc_en;
    w[F_MUL_SEL +: MUL_SEL_W]      = mul_sel;
    w[F_COEF_SEL +: COEF_SEL_W]    = coef;
    w[F_OFS_EN]                    = ofs;
    w[F_RND]                       = rnd;
    return w;
  endfunction

  // Per-mode schedules. Each channel is a three-term dot product: the first
  // term clears the accumulator, the last one writes the channel register.
  // The final step is a round/clamp pass that commits all three channels.
  // Mode 0: YUV BT.601 (signed chroma, no offset), coefficients 0..8.
  // Mode 1: YCbCr full range (chroma +128 offset), coefficients 9..17.
  localparam ctrl_word_t SCHED [SCHED_MODES][SCHED_STEPS] = '{
    '{
      f_uop(MUL_R,   5'd0,  3'b000, 1'b1, 1'b0, 1'b0, 1'b0),
      f_uop(MUL_G,   5'd1,  3'b000, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_B,   5'd2,  3'b001, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_R,   5'd3,  3'b000, 1'b1, 1'b0, 1'b0, 1'b0),
      f_uop(MUL_G,   5'd4,  3'b000, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_B,   5'd5,  3'b010, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_R,   5'd6,  3'b000, 1'b1, 1'b0, 1'b0, 1'b0),
      f_uop(MUL_G,   5'd7,  3'b000, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_B,   5'd8,  3'b100, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_ACC, 5'd0,  3'b111, 1'b0, 1'b0, 1'b0, 1'b1)
    },
    '{
      f_uop(MUL_R,   5'd9,  3'b000, 1'b1, 1'b0, 1'b0, 1'b0),
      f_uop(MUL_G,   5'd10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_B,   5'd11, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_R,   5'd12, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0),
      f_uop(MUL_G,   5'd13, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_B,   5'd14, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0),
      f_uop(MUL_R,   5'd15, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0),
      f_uop(MUL_G,   5'd16, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0),
      f_uop(MUL_B,   5'd17, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0),
      f_uop(MUL_ACC, 5'd0,  3'b111, 1'b0, 1'b0, 1'b0, 1'b1)
    }
  };

endpackage : rgb2yuv_pkg
`default_nettype wire

// File: rtl/rgb2yuv_seq_ctrl_step_rom.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2yuv_seq_ctrl_step_rom
//  Purpose  : Combinational microcode lookup, (mode, step) -> control word.
//             The only consumer of the schedule table, so adding a mode only
//             touches the package.
//  Ports    : mode_i  - latched schedule select
//             step_i  - compute step within the pixel
//             ctrl_o  - datapath control word for that step
//  Revision : 1.0 - initial release
// ============================================================================
module rgb2yuv_seq_ctrl_step_rom
  import rgb2yuv_pkg::*;
#(
  parameter int CTRL_W    = CTRL_WORD_W,
  parameter int STEPS     = SCHED_STEPS,
  parameter int NUM_MODES = SCHED_MODES,
  parameter int MODE_W    = 1,
  parameter int STEP_W    = 4
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  // Any (mode, step) outside both the configured range and the table falls
  // back to HOLD so the datapath freezes instead of running a stray op.
  always_comb begin
    ctrl_o = CTRL_W'(CTRL_HOLD);
    for (int m = 0; m < SCHED_MODES; m++) begin
      for (int s = 0; s < SCHED_STEPS; s++) begin
        if ((m < NUM_MODES) && (s < STEPS) &&
            (int'(mode_i) == m) && (int'(step_i) == s)) begin
          ctrl_o = CTRL_W'(SCHED[m][s]);
        end
      end
    end
  end

endmodule : rgb2yuv_seq_ctrl_step_rom
`default_nettype wire

// File: rtl/rgb2yuv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2yuv_seq_ctrl
//  Purpose  : Frame-level sequencer for the RGB-to-YUV datapath. Fetches
//             pixels over a valid/ready input, runs the per-mode microcode
//             schedule for each pixel, presents the result over a valid/ready
//             output and pulses done after the last pixel.
//  Ports    : clk, rst_n     - clock, async active-low reset
//             start_i        - frame start (IDLE only)
//             abort_i        - synchronous abort, highest priority
//             frame_len_i    - pixels per frame, latched on start
//             mode_i         - schedule select, latched on start
//             in_valid_i / in_ready_o   - pixel input handshake
//             out_valid_o / out_ready_i - result output handshake
//             control_o      - datapath control word
//             busy_o, done_o - status
//             pix_idx_o      - index of pixel in flight
//  Revision : 1.0 - initial release
// ============================================================================
module rgb2yuv_seq_ctrl
  import rgb2yuv_pkg::*;
#(
  parameter int CTRL_W    = CTRL_WORD_W,
  parameter int STEPS     = SCHED_STEPS,
  parameter int LEN_W     = 16,
  parameter int NUM_MODES = SCHED_MODES,
  localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  frame_len_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] control_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  pix_idx_o
);

  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  state_e             state_q,  state_d;
  logic [STEP_W-1:0]  step_q,   step_d;
  logic [LEN_W-1:0]   idx_q,    idx_d;
  logic [LEN_W-1:0]   len_q,    len_d;
  logic [MODE_W-1:0]  mode_q,   mode_d;

  logic [CTRL_W-1:0]  control_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               done_q;

  logic [CTRL_W-1:0]  calc_ctrl;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = frame_len_i;
          mode_d  = mode_i;
          idx_d   = '0;
          step_d  = '0;
          state_d = (frame_len_i == '0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (in_valid_i) begin
          state_d = ST_CALC;
          step_d  = '0;
        end
      end

      ST_CALC: begin
        if (step_q == STEP_LAST) begin
          state_d = ST_OUT;
          step_d  = '0;
        end else begin
          step_d  = step_q + STEP_W'(1);
        end
      end

      ST_OUT: begin
        if (out_ready_i) begin
          // len_q is non-zero here: a zero-length frame never leaves IDLE
          // for LOAD, so len_q - 1 cannot underflow.
          if (idx_q == (len_q - LEN_W'(1))) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = ST_LOAD;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
        idx_d   = '0;
      end
    endcase

    if (abort_i) begin
      state_d = ST_IDLE;
      step_d  = '0;
      idx_d   = '0;
    end
  end

  // Looked up with the next mode/step so the registered control word lines
  // up with the CALC cycle it belongs to.
  rgb2yuv_seq_ctrl_step_rom #(
    .CTRL_W    (CTRL_W),
    .STEPS     (STEPS),
    .NUM_MODES (NUM_MODES),
    .MODE_W    (MODE_W),
    .STEP_W    (STEP_W)
  ) u_step_rom (
    .mode_i (mode_d),
    .step_i (step_d),
    .ctrl_o (calc_ctrl)
  );

  // ---------------------------------------------------------------------------
  // State, counters and registered Moore outputs. Outputs are decoded from the
  // next state so they are valid in the same cycle the state register holds
  // that state, without any combinational path to the ports.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      control_q   <= CTRL_W'(CTRL_IDLE);
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      in_ready_q  <= (state_d == ST_LOAD);
      out_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      case (state_d)
        ST_LOAD: control_q <= CTRL_W'(CTRL_LOAD);
        ST_CALC: control_q <= calc_ctrl;
        ST_OUT:  control_q <= CTRL_W'(CTRL_HOLD);
        default: control_q <= CTRL_W'(CTRL_IDLE);
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign control_o   = control_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pix_idx_o   = idx_q;

endmodule : rgb2yuv_seq_ctrl
`default_nettype wire
